// File: rtl/misr_signature_analyzer.sv
// Multiple-input signature register compacting CUT responses and comparing against a golden value.
// Optional MISR_XMASK_EN adds resp_mask to suppress unknown response bits before compaction.
module misr_signature_analyzer #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned PATTERN_COUNT = 255,
   parameter int unsigned CW            = $clog2(PATTERN_COUNT + 1)
) (
   input  logic             clk,
   input  logic             set,
   input  logic             start,
   input  logic             S,
   input  logic             resp_valid,
   input  logic [WIDTH-1:0] resp,
`ifdef MISR_XMASK_EN
   input  logic [WIDTH-1:0] resp_mask,
`endif
   input  logic [WIDTH-1:0] golden,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] signature,
   output logic [CW-1:0]    count
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPACT = 2'd1,
      ST_COMPARE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [CW-1:0] LAST_IDX = CW'(PATTERN_COUNT - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_sig;
   logic [CW-1:0]    r_count;
   logic             r_mode;
   logic [WIDTH-1:0] r_golden;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;

   logic             w_fb;
   logic [WIDTH-1:0] w_eff_resp;
   logic [WIDTH-1:0] w_sig_next;

`ifdef MISR_XMASK_EN
   assign w_eff_resp = resp & ~resp_mask;
`else
   assign w_eff_resp = resp;
`endif

   // Feedback tap pair chosen by the mode latched at start
   assign w_fb       = r_sig[WIDTH-1] ^ (r_mode ? r_sig[WIDTH-2] : r_sig[0]);
   assign w_sig_next = {r_sig[WIDTH-2:0], w_fb} ^ w_eff_resp;

   always_ff @(posedge clk or negedge set) begin
      if (!set) begin
         r_state  <= ST_IDLE;
         r_sig    <= '0;
         r_count  <= '0;
         r_mode   <= 1'b0;
         r_golden <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_pass   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_state  <= ST_COMPACT;
                  r_sig    <= '0;
                  r_count  <= '0;
                  r_mode   <= S;
                  r_golden <= golden;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
                  r_pass   <= 1'b0;
               end
            end
            ST_COMPACT: begin
               if (resp_valid) begin
                  r_sig   <= w_sig_next;
                  r_count <= r_count + CW'(1);
                  if (r_count == LAST_IDX) begin
                     r_state <= ST_COMPARE;
                  end
               end
            end
            ST_COMPARE: begin
               r_state <= ST_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_pass  <= (r_sig == r_golden);
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign signature = r_sig;
   assign count     = r_count;

endmodule

// File: tb/tb_misr_signature_analyzer.sv
// Directed bench for misr_signature_analyzer with WIDTH=8, PATTERN_COUNT=3.
module tb_misr_signature_analyzer;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned PC    = 3;
   localparam int unsigned CW    = $clog2(PC + 1);

   logic             clk;
   logic             set;
   logic             start;
   logic             S;
   logic             resp_valid;
   logic [WIDTH-1:0] resp;
`ifdef MISR_XMASK_EN
   logic [WIDTH-1:0] resp_mask;
`endif
   logic [WIDTH-1:0] golden;
   logic             busy;
   logic             done;
   logic             pass;
   logic [WIDTH-1:0] signature;
   logic [CW-1:0]    count;

   int n_checks = 0;
   int n_errors = 0;

   misr_signature_analyzer #(.WIDTH(WIDTH), .PATTERN_COUNT(PC)) dut (
      .clk        (clk),
      .set        (set),
      .start      (start),
      .S          (S),
      .resp_valid (resp_valid),
      .resp       (resp),
`ifdef MISR_XMASK_EN
      .resp_mask  (resp_mask),
`endif
      .golden     (golden),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .signature  (signature),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [7:0] e_sig, input logic [7:0] e_cnt,
                            input logic e_busy, input logic e_done, input logic e_pass);
      check({tag, ".sig"},  signature,   e_sig);
      check({tag, ".cnt"},  8'(count),   e_cnt);
      check({tag, ".busy"}, 8'(busy),    8'(e_busy));
      check({tag, ".done"}, 8'(done),    8'(e_done));
      check({tag, ".pass"}, 8'(pass),    8'(e_pass));
   endtask

   task automatic do_start(input logic s_sel, input logic [7:0] gold);
      start = 1'b1; S = s_sel; golden = gold;
      step();
      start = 1'b0;
   endtask

   task automatic accept(input logic [7:0] r);
      resp_valid = 1'b1; resp = r;
      step();
      resp_valid = 1'b0;
   endtask

   initial begin
      set = 1'b0; start = 1'b0; S = 1'b0; resp_valid = 1'b0; resp = '0; golden = '0;
`ifdef MISR_XMASK_EN
      resp_mask = '0;
`endif
      #1;
      check_all("reset", 8'h00, 8'd0, 1'b0, 1'b0, 1'b0);
      step();
      set = 1'b1;
      step();

      // responses in IDLE are ignored
      resp_valid = 1'b1; resp = 8'hA5;
      step();
      resp_valid = 1'b0;
      check_all("idle_ignore", 8'h00, 8'd0, 1'b0, 1'b0, 1'b0);

      // mode 0 pass, with a response on the start cycle and a gap and stray start
      resp_valid = 1'b1; resp = 8'hFF;
      do_start(1'b0, 8'h07);
      resp_valid = 1'b0;
      check_all("m0_start", 8'h00, 8'd0, 1'b1, 1'b0, 1'b0);
      accept(8'h01);
      check_all("m0_acc1", 8'h01, 8'd1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step();
      check_all("m0_gap", 8'h01, 8'd1, 1'b1, 1'b0, 1'b0);
      start = 1'b1; S = 1'b1; golden = 8'h00;
      step();
      start = 1'b0;
      check_all("m0_busy_start", 8'h01, 8'd1, 1'b1, 1'b0, 1'b0);
      accept(8'h00);
      check_all("m0_acc2", 8'h03, 8'd2, 1'b1, 1'b0, 1'b0);
      accept(8'h00);
      check_all("m0_acc3", 8'h07, 8'd3, 1'b1, 1'b0, 1'b0);
      resp_valid = 1'b1; resp = 8'h55;
      step();
      resp_valid = 1'b0;
      check_all("m0_done", 8'h07, 8'd3, 1'b0, 1'b1, 1'b1);
      step();
      check_all("m0_hold", 8'h07, 8'd3, 1'b0, 1'b1, 1'b1);

      // restart from DONE clears done/pass on the same edge
      do_start(1'b0, 8'h00);
      check_all("rs_start", 8'h00, 8'd0, 1'b1, 1'b0, 1'b0);
      accept(8'h00);
      accept(8'h00);
      accept(8'h00);
      step();
      check_all("rs_done", 8'h00, 8'd3, 1'b0, 1'b1, 1'b1);

      // mode 1 fail; S/golden changes after start have no effect
      do_start(1'b1, 8'h07);
      S = 1'b0; golden = 8'h04;
      accept(8'h01);
      check("m1_acc1", signature, 8'h01);
      accept(8'h00);
      check("m1_acc2", signature, 8'h02);
      accept(8'h00);
      check("m1_acc3", signature, 8'h04);
      step();
      check_all("m1_done", 8'h04, 8'd3, 1'b0, 1'b1, 1'b0);

`ifdef MISR_XMASK_EN
      do_start(1'b0, 8'h07);
      resp_mask = 8'h00; accept(8'h01);
      resp_mask = 8'h80; accept(8'h80);
      resp_mask = 8'h00; accept(8'h00);
      step();
      check_all("mask_done", 8'h07, 8'd3, 1'b0, 1'b1, 1'b1);
`else
      do_start(1'b0, 8'h07);
      accept(8'h01);
      accept(8'h80);
      check("nomask_acc2", signature, 8'h83);
      accept(8'h00);
      step();
      check_all("nomask_done", 8'h06, 8'd3, 1'b0, 1'b1, 1'b0);
`endif

      // asynchronous reset mid-COMPACT, between clock edges
      do_start(1'b0, 8'h07);
      accept(8'h01);
      accept(8'h00);
      check("pre_rst_sig", signature, 8'h03);
      #1;
      set = 1'b0;
      #1;
      check_all("async_rst", 8'h00, 8'd0, 1'b0, 1'b0, 1'b0);
      step();
      set = 1'b1;
      step();
      check_all("post_rst", 8'h00, 8'd0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
